// File: rtl/lcd1602_pkg.sv
// rtl/lcd1602_pkg.sv - shared states, LCD command bytes and sizes for the LCD1602 controller
package lcd1602_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LINE1_ADDR,
    ST_LINE1_DATA,
    ST_LINE2_ADDR,
    ST_LINE2_DATA
  } lcd_state_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam int MSG_LEN  = 16;
  localparam int INIT_LEN = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd1602_controller_msg_rom.sv
// rtl/lcd1602_controller_msg_rom.sv - combinational message ROM, index + column -> ASCII byte
module lcd_msg_rom
  import lcd1602_pkg::*;
(
  input  logic [2:0] idx,
  input  logic [3:0] col,
  output logic [7:0] chr
);

  localparam logic [8*MSG_LEN-1:0] MSG_BLANK  = {MSG_LEN{8'h20}};
  localparam logic [8*MSG_LEN-1:0] MSG_PERFIL = "INGRESE PERFIL *";
  localparam logic [8*MSG_LEN-1:0] MSG_CLAVE  = {"DIGITE CLAVE *", {2{8'h20}}};
  localparam logic [8*MSG_LEN-1:0] MSG_ABIER  = {"ABIERTO", {9{8'h20}}};
  localparam logic [8*MSG_LEN-1:0] MSG_INTRU  = {"INTRUSO", {9{8'h20}}};

  logic [8*MSG_LEN-1:0] line;

  // Column 0 is the leftmost character, held in the most significant byte.
  always_comb begin
    case (idx)
      3'd1:    line = MSG_PERFIL;
      3'd2:    line = MSG_CLAVE;
      3'd3:    line = MSG_ABIER;
      3'd4:    line = MSG_INTRU;
      default: line = MSG_BLANK;
    endcase
    chr = line[8*(MSG_LEN-1-int'(col)) +: 8];
  end

endmodule

// File: rtl/lcd1602_controller.sv
// rtl/lcd1602_controller.sv - LCD1602 write sequencer: init, then refresh line 1 message and line 2 char
module lcd1602_controller
  import lcd1602_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int WAIT_CYCLES = 100_000,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ready_i,
  input  logic [7:0]           in1,
  input  logic [2:0]           vis1,
  output logic                 rs,
  output logic                 rw,
  output logic                 enable,
  output logic [DATA_BITS-1:0] data
);

  localparam int CW   = $clog2(WAIT_CYCLES);
  localparam int HALF = WAIT_CYCLES / 2;

  if (CLK_FREQ <= 0 || WAIT_CYCLES < 4 || (WAIT_CYCLES % 2) != 0) begin : g_param_check
    $error("lcd1602_controller: invalid CLK_FREQ or WAIT_CYCLES");
  end

  lcd_state_e           state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [3:0]           step_q, step_d;
  logic                 rs_q, rs_d;
  logic                 en_q, en_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [2:0]           vis_q, vis_d;
  logic [7:0]           in1_q, in1_d;

  logic                 load;
  logic [7:0]           byte_nx;
  logic [DATA_BITS-1:0] byte_fit;
  logic [3:0]           rom_col;
  logic [7:0]           rom_chr;

  // The ROM is addressed with the column of the slot about to start.
  assign rom_col = (state_q == ST_LINE1_DATA) ? step_q + 4'd1 : 4'd0;

  lcd_msg_rom u_rom (
    .idx (vis_q),
    .col (rom_col),
    .chr (rom_chr)
  );

  if (DATA_BITS == 8) begin : g_fit_eq
    assign byte_fit = byte_nx;
  end else if (DATA_BITS > 8) begin : g_fit_wide
    assign byte_fit = {{(DATA_BITS-8){1'b0}}, byte_nx};
  end else begin : g_fit_narrow
    assign byte_fit = byte_nx[DATA_BITS-1:0];
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    step_d  = step_q;
    rs_d    = rs_q;
    en_d    = en_q;
    vis_d   = vis_q;
    in1_d   = in1_q;
    load    = 1'b0;
    byte_nx = 8'h00;

    if (state_q == ST_IDLE) begin
      en_d   = 1'b0;
      cyc_d  = '0;
      step_d = '0;
      if (ready_i) begin
        state_d = ST_INIT;
        rs_d    = 1'b0;
        byte_nx = CMD_FUNC_SET;
        load    = 1'b1;
        en_d    = 1'b1;
      end
    end else if (cyc_q != CW'(WAIT_CYCLES-1)) begin
      cyc_d = cyc_q + 1'b1;
      en_d  = (cyc_q + 1'b1) < CW'(HALF);
    end else begin
      cyc_d = '0;
      load  = 1'b1;
      case (state_q)
        ST_INIT: begin
          rs_d = 1'b0;
          if (step_q == 4'(INIT_LEN-1)) begin
            state_d = ST_LINE1_ADDR;
            step_d  = '0;
            byte_nx = CMD_LINE1;
            vis_d   = vis1;
            in1_d   = in1;
          end else begin
            step_d  = step_q + 4'd1;
            byte_nx = init_cmd(step_q[1:0] + 2'd1);
          end
        end
        ST_LINE1_ADDR: begin
          state_d = ST_LINE1_DATA;
          step_d  = '0;
          rs_d    = 1'b1;
          byte_nx = rom_chr;
        end
        ST_LINE1_DATA: begin
          if (step_q == 4'(MSG_LEN-1)) begin
            state_d = ST_LINE2_ADDR;
            step_d  = '0;
            rs_d    = 1'b0;
            byte_nx = CMD_LINE2;
          end else begin
            step_d  = step_q + 4'd1;
            rs_d    = 1'b1;
            byte_nx = rom_chr;
          end
        end
        ST_LINE2_ADDR: begin
          state_d = ST_LINE2_DATA;
          rs_d    = 1'b1;
          byte_nx = in1_q;
        end
        ST_LINE2_DATA: begin
          // Inputs are re-latched here so a running refresh picks up new values.
          if (ready_i) begin
            state_d = ST_LINE1_ADDR;
            rs_d    = 1'b0;
            byte_nx = CMD_LINE1;
            vis_d   = vis1;
            in1_d   = in1;
          end else begin
            state_d = ST_IDLE;
            load    = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          load    = 1'b0;
        end
      endcase
      en_d = load;
    end
  end

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = byte_fit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      step_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= '0;
      vis_q   <= '0;
      in1_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      step_q  <= step_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      data_q  <= data_d;
      vis_q   <= vis_d;
      in1_q   <= in1_d;
    end
  end

  assign rs     = rs_q;
  assign rw     = 1'b0;
  assign enable = en_q;
  assign data   = data_q;

endmodule

// File: tb/tb_lcd1602_controller.sv
// tb/tb_lcd1602_controller.sv - scoreboard bench for lcd1602_controller with a message-level model
module tb_lcd1602_controller;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready_i;
  logic [7:0] in1;
  logic [2:0] vis1;
  logic       rs;
  logic       rw;
  logic       enable;
  logic [7:0] data;

  lcd1602_controller #(
    .CLK_FREQ    (50_000_000),
    .WAIT_CYCLES (W),
    .DATA_BITS   (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ready_i (ready_i),
    .in1     (in1),
    .vis1    (vis1),
    .rs      (rs),
    .rw      (rw),
    .enable  (enable),
    .data    (data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic       cont;
  } exp_t;

  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    slots_seen = 0;
  bit    abort = 1'b0;
  string msg[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [7:0] msg_char(input int v, input int c);
    if (c < msg[v].len()) return msg[v][c];
    return 8'h20;
  endfunction

  task automatic push_slot(input logic r, input logic [7:0] d, input logic cont);
    exp_t e;
    e.rs = r;
    e.d = d;
    e.cont = cont;
    exp_q.push_back(e);
  endtask

  task automatic push_init(input logic cont_first);
    push_slot(1'b0, 8'h38, cont_first);
    push_slot(1'b0, 8'h0C, 1'b1);
    push_slot(1'b0, 8'h01, 1'b1);
    push_slot(1'b0, 8'h06, 1'b1);
  endtask

  task automatic push_pass(input int v, input logic [7:0] c);
    push_slot(1'b0, 8'h80, 1'b1);
    for (int k = 0; k < 16; k++) push_slot(1'b1, msg_char(v, k), 1'b1);
    push_slot(1'b0, 8'hC0, 1'b1);
    push_slot(1'b1, c, 1'b1);
  endtask

  task automatic wait_slots(input int target, input string name);
    for (int i = 0; i < 3000; i++) begin
      if (slots_seen >= target) break;
      @(negedge clk);
    end
    check({"reach_", name}, (slots_seen >= target), 1);
  endtask

  // Monitor: every rising enable starts a slot that must match the next expected entry.
  initial begin : monitor
    int   pos;
    int   cyc;
    int   last_start;
    bit   in_slot;
    logic prev_en;
    logic [7:0] sd;
    logic srs;
    exp_t e;
    pos = 0; cyc = 0; last_start = -100; in_slot = 0; prev_en = 1'b0; sd = 8'h00; srs = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (abort) begin
        abort = 1'b0;
        in_slot = 0;
      end else if (enable === 1'b1 && prev_en !== 1'b1) begin
        slots_seen++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe got rs=%b data=%h expected no strobe", rs, data);
        end else begin
          e = exp_q.pop_front();
          check("slot_rs", rs, e.rs);
          check("slot_data", data, e.d);
          check("slot_rw", rw, 0);
          if (e.cont) check("slot_gap", cyc - last_start, W);
        end
        last_start = cyc;
        in_slot = 1;
        pos = 0;
        sd = data;
        srs = rs;
      end else if (in_slot) begin
        pos++;
        check("strobe_shape", enable, (pos < W/2));
        check("slot_hold", {srs, sd}, {rs, data});
        if (pos == W - 1) in_slot = 0;
      end
      prev_en = enable;
    end
  end

  initial begin : watchdog
    #400_000;
    $display("FAIL watchdog got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int         p80;
    int         base;
    int         v;
    logic [7:0] c;
    logic       last_en;

    msg[0] = "";
    msg[1] = "INGRESE PERFIL *";
    msg[2] = "DIGITE CLAVE *";
    msg[3] = "ABIERTO";
    msg[4] = "INTRUSO";
    msg[5] = "";
    msg[6] = "";
    msg[7] = "";

    reset = 1'b1; ready_i = 1'b0; vis1 = 3'd0; in1 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_enable", enable, 0);
    check("reset_data", data, 0);
    check("reset_rs", rs, 0);
    check("reset_rw", rw, 0);

    vis1 = 3'd3; in1 = 8'h35;
    push_init(1'b0);
    push_pass(3, 8'h35);
    reset = 1'b0; ready_i = 1'b1;
    wait_slots(5, "pass1");

    vis1 = 3'd1; in1 = 8'h41;
    push_pass(1, 8'h41);
    wait_slots(27, "pass2_data");
    in1 = 8'h42;
    push_pass(1, 8'h42);
    p80 = 43;
    wait_slots(p80, "pass3");

    for (int k = 0; k < 4; k++) begin
      v = int'($urandom_range(7, 0));
      c = 8'($urandom_range(126, 32));
      vis1 = 3'(v); in1 = c;
      push_pass(v, c);
      p80 += 19;
      wait_slots(p80, "rand_pass");
    end

    wait_slots(p80 + 3, "drop_point");
    ready_i = 1'b0;
    wait_slots(p80 + 18, "drop_pass_end");
    repeat (60) @(negedge clk);
    check("drop_queue_empty", exp_q.size(), 0);
    check("drop_slot_count", slots_seen, p80 + 18);
    check("drop_idle_enable", enable, 0);

    base = slots_seen;
    v = int'($urandom_range(4, 1));
    c = 8'($urandom_range(126, 32));
    vis1 = 3'(v); in1 = c;
    push_init(1'b0);
    push_pass(v, c);
    ready_i = 1'b1;
    wait_slots(base + 8, "restart");

    last_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (enable === 1'b1 && last_en === 1'b1) break;
      last_en = enable;
    end
    check("pre_reset_enable", enable, 1);
    reset = 1'b1;
    abort = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midreset_enable", enable, 0);
    check("midreset_data", data, 0);
    check("midreset_rs", rs, 0);
    reset = 1'b0;
    base = slots_seen;
    push_init(1'b0);
    push_pass(v, c);
    wait_slots(base + 8, "post_reset");
    ready_i = 1'b0;
    wait_slots(base + 23, "post_reset_end");
    repeat (40) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_idle_enable", enable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
